// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the FP issue controller.
//   - opcode encodings (FPU_OP_*)
//   - FSM state type (fpu_state_e)
//   - latency-select type (fpu_lat_sel_e)
//   - bit positions inside the 10-bit strobe vector
//   - default execute latencies
package fpu_pkg;

    localparam logic [3:0] FPU_OP_ADD = 4'd0;
    localparam logic [3:0] FPU_OP_SUB = 4'd1;
    localparam logic [3:0] FPU_OP_MUL = 4'd2;
    localparam logic [3:0] FPU_OP_DIV = 4'd3;
    localparam logic [3:0] FPU_OP_INV = 4'd4;
    localparam logic [3:0] FPU_OP_ABS = 4'd5;
    localparam logic [3:0] FPU_OP_BLT = 4'd6;
    localparam logic [3:0] FPU_OP_BEQ = 4'd7;
    localparam logic [3:0] FPU_OP_BGT = 4'd8;

    localparam int FPU_LAT_ADD_DEF = 1;
    localparam int FPU_LAT_MUL_DEF = 4;
    localparam int FPU_LAT_DIV_DEF = 16;

    // Strobe vector layout, MSB first: ADD SUB MUL DIV INV ABS COM BLT BEQ BGT
    localparam int STB_ADD = 9;
    localparam int STB_SUB = 8;
    localparam int STB_MUL = 7;
    localparam int STB_DIV = 6;
    localparam int STB_INV = 5;
    localparam int STB_ABS = 4;
    localparam int STB_COM = 3;
    localparam int STB_BLT = 2;
    localparam int STB_BEQ = 1;
    localparam int STB_BGT = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } fpu_state_e;

    typedef enum logic [1:0] {
        LAT_SEL_ADD = 2'd0,
        LAT_SEL_MUL = 2'd1,
        LAT_SEL_DIV = 2'd2
    } fpu_lat_sel_e;

endpackage

// File: rtl/fpu_op_decoder.sv
// fpu_op_decoder: combinational opcode decode.
//   opcode    in  4   instruction opcode
//   strobes   out 10  one-hot ALU strobe set (COM added for branches)
//   lat_sel   out     which execute latency applies
//   is_branch out 1   opcode is BLT/BEQ/BGT
//   illegal   out 1   opcode 9..15
module fpu_op_decoder
    import fpu_pkg::*;
(
    input  logic [3:0]   opcode,
    output logic [9:0]   strobes,
    output fpu_lat_sel_e lat_sel,
    output logic         is_branch,
    output logic         illegal
);

    always_comb begin
        strobes   = '0;
        lat_sel   = LAT_SEL_ADD;
        is_branch = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            FPU_OP_ADD: strobes[STB_ADD] = 1'b1;
            FPU_OP_SUB: strobes[STB_SUB] = 1'b1;
            FPU_OP_MUL: begin
                strobes[STB_MUL] = 1'b1;
                lat_sel          = LAT_SEL_MUL;
            end
            FPU_OP_DIV: begin
                strobes[STB_DIV] = 1'b1;
                lat_sel          = LAT_SEL_DIV;
            end
            FPU_OP_INV: strobes[STB_INV] = 1'b1;
            FPU_OP_ABS: strobes[STB_ABS] = 1'b1;
            FPU_OP_BLT: begin
                strobes[STB_COM] = 1'b1;
                strobes[STB_BLT] = 1'b1;
                is_branch        = 1'b1;
            end
            FPU_OP_BEQ: begin
                strobes[STB_COM] = 1'b1;
                strobes[STB_BEQ] = 1'b1;
                is_branch        = 1'b1;
            end
            FPU_OP_BGT: begin
                strobes[STB_COM] = 1'b1;
                strobes[STB_BGT] = 1'b1;
                is_branch        = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: sequences one FP instruction into the combinational ALU.
//   clk, rst_n            clock, async active-low reset
//   start, opcode         request (sampled in IDLE only)
//   rs_data, rt_data      source operands
//   flush                 synchronous abort, beats start
//   alu_result/com_result ALU outputs, sampled at end of EXEC
//   operand1/2, strobes   registered ALU inputs, held through EXEC
//   busy, done, wb_en, wb_data, branch_valid, branch_taken, err  status/results
// Handshake: start is accepted on a rising edge where state is IDLE and flush
// is low; there is no back-pressure, requests while busy are dropped. done is
// a single-cycle pulse, and wb_en/branch_valid/err are only meaningful with it.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int LAT_ADD = FPU_LAT_ADD_DEF,
    parameter int LAT_MUL = FPU_LAT_MUL_DEF,
    parameter int LAT_DIV = FPU_LAT_DIV_DEF,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  opcode,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    input  logic [31:0] alu_result,
    input  logic        alu_com_result,
    output logic [31:0] operand1,
    output logic [31:0] operand2,
    output logic        ADD,
    output logic        SUB,
    output logic        MUL,
    output logic        DIV,
    output logic        INV,
    output logic        ABS,
    output logic        COM,
    output logic        BLT,
    output logic        BEQ,
    output logic        BGT,
    output logic        busy,
    output logic        done,
    output logic        wb_en,
    output logic [31:0] wb_data,
    output logic        branch_valid,
    output logic        branch_taken,
    output logic        err
);

    fpu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      op1_q, op1_d;
    logic [31:0]      op2_q, op2_d;
    logic [9:0]       strb_q, strb_d;
    logic             is_branch_q, is_branch_d;
    logic             err_q, err_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             taken_q, taken_d;

    logic [9:0]       dec_strobes;
    fpu_lat_sel_e     dec_lat_sel;
    logic             dec_is_branch;
    logic             dec_illegal;
    logic [CNT_W-1:0] lat_load;

    fpu_op_decoder u_dec (
        .opcode    (opcode),
        .strobes   (dec_strobes),
        .lat_sel   (dec_lat_sel),
        .is_branch (dec_is_branch),
        .illegal   (dec_illegal)
    );

    // Counter is loaded with L-1 so that L cycles elapse before capture.
    always_comb begin
        case (dec_lat_sel)
            LAT_SEL_MUL: lat_load = CNT_W'(LAT_MUL - 1);
            LAT_SEL_DIV: lat_load = CNT_W'(LAT_DIV - 1);
            default:     lat_load = CNT_W'(LAT_ADD - 1);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        strb_d      = strb_q;
        is_branch_d = is_branch_q;
        err_d       = err_q;
        wb_data_d   = wb_data_q;
        taken_d     = taken_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (dec_illegal) begin
                        // Illegal ops never touch the ALU; report straight away.
                        err_d       = 1'b1;
                        is_branch_d = 1'b0;
                        state_d     = ST_DONE;
                    end else begin
                        op1_d       = rs_data;
                        op2_d       = rt_data;
                        strb_d      = dec_strobes;
                        cnt_d       = lat_load;
                        is_branch_d = dec_is_branch;
                        err_d       = 1'b0;
                        state_d     = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    wb_data_d = alu_result;
                    taken_d   = is_branch_q & alu_com_result;
                    strb_d    = '0;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over everything; captured results are left untouched.
        if (flush) begin
            state_d   = ST_IDLE;
            strb_d    = '0;
            cnt_d     = '0;
            err_d     = 1'b0;
            wb_data_d = wb_data_q;
            taken_d   = taken_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            strb_q      <= '0;
            is_branch_q <= 1'b0;
            err_q       <= 1'b0;
            wb_data_q   <= '0;
            taken_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            strb_q      <= strb_d;
            is_branch_q <= is_branch_d;
            err_q       <= err_d;
            wb_data_q   <= wb_data_d;
            taken_q     <= taken_d;
        end
    end

    assign operand1 = op1_q;
    assign operand2 = op2_q;
    assign {ADD, SUB, MUL, DIV, INV, ABS, COM, BLT, BEQ, BGT} = strb_q;

    // A flush during the DONE cycle suppresses that cycle's completion.
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE) && !flush;
    assign wb_en        = done && !err_q && !is_branch_q;
    assign branch_valid = done && !err_q && is_branch_q;
    assign err          = done && err_q;
    assign wb_data      = wb_data_q;
    assign branch_taken = taken_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
module tb_fpu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  opcode;
    logic [31:0] rs_data, rt_data;
    logic        flush;
    logic [31:0] alu_result;
    logic        alu_com_result;
    logic [31:0] operand1, operand2;
    logic        ADD, SUB, MUL, DIV, INV, ABS, COM, BLT, BEQ, BGT;
    logic        busy, done, wb_en, branch_valid, branch_taken, err;
    logic [31:0] wb_data;
    logic [9:0]  strobes;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fpu_issue_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .opcode         (opcode),
        .rs_data        (rs_data),
        .rt_data        (rt_data),
        .flush          (flush),
        .alu_result     (alu_result),
        .alu_com_result (alu_com_result),
        .operand1       (operand1),
        .operand2       (operand2),
        .ADD            (ADD),
        .SUB            (SUB),
        .MUL            (MUL),
        .DIV            (DIV),
        .INV            (INV),
        .ABS            (ABS),
        .COM            (COM),
        .BLT            (BLT),
        .BEQ            (BEQ),
        .BGT            (BGT),
        .busy           (busy),
        .done           (done),
        .wb_en          (wb_en),
        .wb_data        (wb_data),
        .branch_valid   (branch_valid),
        .branch_taken   (branch_taken),
        .err            (err)
    );

    assign strobes = {ADD, SUB, MUL, DIV, INV, ABS, COM, BLT, BEQ, BGT};

    // Behavioural combinational ALU driven by the strobes.
    always_comb begin
        alu_result     = 32'h0;
        alu_com_result = 1'b0;
        if (ADD) alu_result = operand1 + operand2;
        if (SUB) alu_result = operand1 - operand2;
        if (MUL) alu_result = operand1 * operand2;
        if (DIV) alu_result = (operand2 == 32'h0) ? 32'h0 : operand1 / operand2;
        if (INV) alu_result = ~operand1;
        if (ABS) alu_result = operand1 & 32'h7fff_ffff;
        if (BLT) alu_com_result = (operand1 < operand2);
        if (BEQ) alu_com_result = (operand1 == operand2);
        if (BGT) alu_com_result = (operand1 > operand2);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one rising edge; returns 1ns after that edge (T).
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start   = 1'b1;
        opcode  = op;
        rs_data = a;
        rt_data = b;
        step();
        start   = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        opcode  = 4'd0;
        rs_data = 32'h0;
        rt_data = 32'h0;
        flush   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_strobes", {22'h0, strobes}, 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        rst_n = 1'b1;
        step();

        // ---- ADD 5+3, L=1
        issue(4'd0, 32'h5, 32'h3);
        chk("add_strobes_T", {22'h0, strobes}, 32'h200);
        chk("add_op1", operand1, 32'h5);
        chk("add_op2", operand2, 32'h3);
        chk("add_busy_T", {31'h0, busy}, 32'h1);
        chk("add_done_T", {31'h0, done}, 32'h0);
        step();
        chk("add_done_T1", {31'h0, done}, 32'h1);
        chk("add_wb_en", {31'h0, wb_en}, 32'h1);
        chk("add_wb_data", wb_data, 32'h8);
        chk("add_strobes_T1", {22'h0, strobes}, 32'h0);
        chk("add_busy_T1", {31'h0, busy}, 32'h1);
        chk("add_bvalid", {31'h0, branch_valid}, 32'h0);
        step();
        chk("add_done_T2", {31'h0, done}, 32'h0);
        chk("add_busy_T2", {31'h0, busy}, 32'h0);
        chk("add_wb_hold", wb_data, 32'h8);

        // ---- SUB 9-4
        issue(4'd1, 32'h9, 32'h4);
        chk("sub_strobes", {22'h0, strobes}, 32'h100);
        step();
        chk("sub_wb_data", wb_data, 32'h5);
        chk("sub_wb_en", {31'h0, wb_en}, 32'h1);
        step();

        // ---- MUL 6*7, L=4
        issue(4'd2, 32'h6, 32'h7);
        chk("mul_strobes", {22'h0, strobes}, 32'h080);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("mul_no_done", {31'h0, done}, 32'h0);
            chk("mul_held", {31'h0, MUL}, 32'h1);
        end
        step();
        chk("mul_done_T4", {31'h0, done}, 32'h1);
        chk("mul_wb_data", wb_data, 32'd42);
        step();

        // ---- DIV 100/7, L=16, start at T+5 ignored
        issue(4'd3, 32'd100, 32'd7);
        chk("div_strobes_T", {22'h0, strobes}, 32'h040);
        for (int k = 1; k <= 15; k++) begin
            if (k == 5) start = 1'b1;
            opcode = 4'd0;
            step();
            start = 1'b0;
            chk("div_held", {31'h0, DIV}, 32'h1);
            chk("div_no_done", {31'h0, done}, 32'h0);
        end
        step();
        chk("div_done_T16", {31'h0, done}, 32'h1);
        chk("div_wb_data", wb_data, 32'd14);
        chk("div_strobe_off", {22'h0, strobes}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("div_no_second_done", {31'h0, done}, 32'h0);
            chk("div_idle", {31'h0, busy}, 32'h0);
        end

        // ---- BEQ 0x1234 == 0x1234
        issue(4'd7, 32'h1234, 32'h1234);
        chk("beq_strobes", {22'h0, strobes}, 32'h00a);
        step();
        chk("beq_done", {31'h0, done}, 32'h1);
        chk("beq_bvalid", {31'h0, branch_valid}, 32'h1);
        chk("beq_taken", {31'h0, branch_taken}, 32'h1);
        chk("beq_wb_en", {31'h0, wb_en}, 32'h0);
        step();

        // ---- BGT 3 > 5 is false
        issue(4'd8, 32'h3, 32'h5);
        chk("bgt_strobes", {22'h0, strobes}, 32'h009);
        step();
        chk("bgt_bvalid", {31'h0, branch_valid}, 32'h1);
        chk("bgt_taken", {31'h0, branch_taken}, 32'h0);
        step();

        // ---- ADD 10+20 then illegal opcode 12
        issue(4'd0, 32'd10, 32'd20);
        step();
        chk("add2_wb_data", wb_data, 32'd30);
        step();
        issue(4'd12, 32'hdead, 32'hbeef);
        chk("ill_strobes", {22'h0, strobes}, 32'h0);
        chk("ill_done", {31'h0, done}, 32'h1);
        chk("ill_err", {31'h0, err}, 32'h1);
        chk("ill_wb_en", {31'h0, wb_en}, 32'h0);
        chk("ill_bvalid", {31'h0, branch_valid}, 32'h0);
        chk("ill_wb_hold", wb_data, 32'd30);
        step();
        chk("ill_busy_T1", {31'h0, busy}, 32'h0);
        chk("ill_err_T1", {31'h0, err}, 32'h0);
        chk("ill_strobes_T1", {22'h0, strobes}, 32'h0);

        // ---- MUL flushed during T+2..T+3
        issue(4'd2, 32'h6, 32'h7);
        step();
        step();
        chk("fl_mul_held", {31'h0, MUL}, 32'h1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_busy", {31'h0, busy}, 32'h0);
        chk("fl_strobes", {22'h0, strobes}, 32'h0);
        chk("fl_wb_hold", wb_data, 32'd30);
        for (int k = 0; k < 3; k++) begin
            chk("fl_no_done", {31'h0, done}, 32'h0);
            step();
        end

        // ---- flush beats start in IDLE
        flush = 1'b1;
        issue(4'd0, 32'h1, 32'h1);
        flush = 1'b0;
        chk("fl_prio_busy", {31'h0, busy}, 32'h0);
        chk("fl_prio_strobes", {22'h0, strobes}, 32'h0);
        step();

        // ---- ADD after flush
        issue(4'd0, 32'h1, 32'h2);
        chk("post_fl_add", {31'h0, ADD}, 32'h1);
        step();
        chk("post_fl_done", {31'h0, done}, 32'h1);
        chk("post_fl_wb", wb_data, 32'h3);
        step();

        // ---- reset mid DIV
        issue(4'd3, 32'd50, 32'd5);
        repeat (7) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstm_busy", {31'h0, busy}, 32'h0);
        chk("rstm_strobes", {22'h0, strobes}, 32'h0);
        chk("rstm_op1", operand1, 32'h0);
        chk("rstm_op2", operand2, 32'h0);
        chk("rstm_wb_data", wb_data, 32'h0);
        chk("rstm_flags", {26'h0, done, wb_en, branch_valid, branch_taken, err, busy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        issue(4'd0, 32'h2, 32'h2);
        chk("rstm_add_busy", {31'h0, busy}, 32'h1);
        step();
        chk("rstm_add_done", {31'h0, done}, 32'h1);
        chk("rstm_add_wb", wb_data, 32'h4);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
